// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the multiply-accumulate datapath.
package mac_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_WEIGHT_W = 16;
    localparam int DEF_TAPS     = 8;
    localparam int DEF_ACC_W    = 40;
    localparam int DEF_OUT_W    = 16;
    localparam int DEF_SHIFT    = 0;

    // Bits needed to index 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation to OUT_W.
module mac_round_sat #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] result,
    output logic             sat
);

    // One guard bit so adding the rounding constant can never overflow.
    localparam int EXT_W = ACC_W + 1;

    logic signed [EXT_W-1:0]     sum_ext;
    logic signed [EXT_W-1:0]     rnd;
    logic        [EXT_W-OUT_W:0] upper;

    assign sum_ext = EXT_W'($signed(sum));

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
            assign rnd = (sum_ext + HALF) >>> SHIFT;
        end else begin : g_pass
            assign rnd = sum_ext;
        end
    endgenerate

    // Fits in OUT_W only when every bit from the OUT_W sign bit upward agrees.
    assign upper = rnd[EXT_W-1:OUT_W-1];
    assign sat   = !((&upper) || !(|upper));

    always_comb begin
        result = rnd[OUT_W-1:0];
        if (sat) begin
            result = rnd[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_accum_n.sv
// TAPS-deep signed multiply-accumulate: product stage, accumulate stage, then a
// rounded/saturated output register with valid/ready handshakes on both sides.
module mac_accum_n
    import mac_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int TAPS     = DEF_TAPS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   data,
    input  logic [WEIGHT_W-1:0] weight,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    result,
    output logic                sat
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic                     stall;
    logic                     accept;
    logic [CNT_W-1:0]         tap_cnt;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic                     s2_done;
    logic [OUT_W-1:0]         rs_result;
    logic                     rs_sat;

    // A held, unconsumed result freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready && !clear;

    assign prod_c   = PROD_W'($signed(data)) * PROD_W'($signed(weight));
    assign prod_ext = ACC_W'(s1_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt <= '0;
        end else if (clear) begin
            tap_cnt <= '0;
        end else if (accept) begin
            tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_first <= (tap_cnt == '0);
            s1_last  <= (tap_cnt == LAST_TAP);
            s1_prod  <= prod_c;
        end
    end

    // The first tap loads rather than adds, so no flush cycle is needed between vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            s2_done <= 1'b0;
        end else if (clear) begin
            s2_done <= 1'b0;
        end else if (!stall) begin
            s2_done <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= s1_first ? prod_ext : acc + prod_ext;
            end
        end
    end

    mac_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum    (acc),
        .result (rs_result),
        .sat    (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_done;
            if (s2_done) begin
                result <= rs_result;
                sat    <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_n.sv
// Directed bench for mac_accum_n: one SHIFT=0 and one SHIFT=2 instance share all inputs.
module tb_mac_accum_n;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data;
    logic [15:0] weight;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        sat;
    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] result2;
    logic        sat2;

    int n_checks;
    int n_errors;
    int dv[8];
    int wv[8];

    mac_accum_n #(.SHIFT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat)
    );

    mac_accum_n #(.SHIFT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .data      (data),
        .weight    (weight),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .result    (result2),
        .sat       (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_vec();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            data     = 16'(dv[i]);
            weight   = 16'(wv[i]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Last beat was accepted on the edge just passed; result appears two edges later.
    task automatic expect_vec(input string tag, input int e0, input int s0, input int e2, input int s2);
        chk({tag, "_lat0"}, int'(out_valid), 0);
        tick();
        chk({tag, "_lat1"}, int'(out_valid), 0);
        tick();
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_result"}, int'($signed(result)), e0);
        chk({tag, "_sat"}, int'(sat), s0);
        chk({tag, "_valid2"}, int'(out_valid2), 1);
        chk({tag, "_result2"}, int'($signed(result2)), e2);
        chk({tag, "_sat2"}, int'(sat2), s2);
        tick();
        chk({tag, "_pulse"}, int'(out_valid), 0);
    endtask

    initial begin
        int k;
        int hs;
        int stall_left;
        int stall_cyc;
        bit first_seen;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        data      = '0;
        weight    = '0;
        out_ready = 1'b1;

        #3;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_sat", int'(sat), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // 1..8 times 2 = 72
        for (int i = 0; i < 8; i++) begin dv[i] = i + 1; wv[i] = 2; end
        send_vec();
        expect_vec("basic", 72, 0, 18, 0);

        // Rounding on the SHIFT=2 instance: 6 -> 2, -6 -> -1, 5 -> 1
        for (int i = 0; i < 8; i++) begin dv[i] = 0; wv[i] = 1; end
        dv[0] = 6;
        send_vec();
        expect_vec("rnd_p6", 6, 0, 2, 0);
        dv[0] = -6;
        send_vec();
        expect_vec("rnd_m6", -6, 0, -1, 0);
        dv[0] = 5;
        send_vec();
        expect_vec("rnd_p5", 5, 0, 1, 0);

        // Saturation both ways
        for (int i = 0; i < 8; i++) begin dv[i] = 32767; wv[i] = 32767; end
        send_vec();
        expect_vec("sat_pos", 32767, 1, 32767, 1);
        for (int i = 0; i < 8; i++) begin dv[i] = -32768; wv[i] = 32767; end
        send_vec();
        expect_vec("sat_neg", -32768, 1, -32768, 1);

        // Back-to-back vectors (36 then -240) with a 5-cycle output stall
        k          = 0;
        hs         = 0;
        stall_left = 0;
        stall_cyc  = 0;
        first_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && hs < 2; cyc++) begin
            in_valid = (k < 16);
            data     = (k < 8) ? 16'(k + 1) : 16'(10);
            weight   = (k < 8) ? 16'(1) : 16'(-3);
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 5;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_hold", int'($signed(result)), 36);
                stall_left--;
                stall_cyc++;
            end else begin
                chk("run_in_ready", int'(in_ready), 1);
            end
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                hs++;
                chk("b2b_result", int'($signed(result)), (hs == 1) ? 36 : -240);
                chk("b2b_result2", int'($signed(result2)), (hs == 1) ? 9 : -60);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b_beats", k, 16);
        chk("b2b_results", hs, 2);
        chk("b2b_stall_cycles", stall_cyc, 5);
        tick();
        tick();

        // Clear after 3 taps; the beat offered during clear is dropped
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data     = 16'(5);
            weight   = 16'(5);
            tick();
        end
        clear  = 1'b1;
        data   = 16'(100);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_in_ready", int'(in_ready), 1);
        chk("clear_out_valid", int'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin dv[i] = 1; wv[i] = 1; end
        send_vec();
        expect_vec("after_clear", 8, 0, 2, 0);

        // Async reset while a result is held and a new vector is partially in
        for (int i = 0; i < 8; i++) begin dv[i] = i + 1; wv[i] = 2; end
        send_vec();
        in_valid = 1'b1;
        data     = 16'(9);
        weight   = 16'(9);
        tick();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_result", int'($signed(result)), 72);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", int'(in_ready), 0);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_result", int'(result), 0);
        chk("async_sat", int'(sat), 0);
        chk("async_result2", int'(result2), 0);
        #2;
        rst = 1'b0;
        #1;
        out_ready = 1'b1;
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_out_valid", int'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin dv[i] = 3; wv[i] = -1; end
        send_vec();
        expect_vec("after_rst", -24, 0, -6, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_accum_n.md
MAC_ACCUM_N -- requirements
Module: mac_accum_n

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed data operand width.
REQ-002 SHALL have parameter WEIGHT_W, default 16, meaning signed weight operand width.
REQ-003 SHALL have parameter TAPS, default 8, meaning products summed per result (range 2..256).
REQ-004 SHALL have parameter ACC_W, default 40, meaning signed accumulator width.
REQ-005 SHALL have parameter OUT_W, default 16, meaning signed result width.
REQ-006 SHALL have parameter SHIFT, default 0, meaning right-shift applied to the sum before saturation (0..ACC_W-1).
REQ-007 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port clear  input  1  synchronous flush of the partial vector and pipeline.
REQ-010 SHALL have port in_valid  input  1  data/weight beat offered.
REQ-011 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-012 SHALL have port data  input  DATA_W  signed data operand.
REQ-013 SHALL have port weight  input  WEIGHT_W  signed weight operand.
REQ-014 SHALL have port out_valid  output  1  result held valid.
REQ-015 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-016 SHALL have port result  output  OUT_W  signed rounded, saturated sum.
REQ-017 SHALL have port sat  output  1  result was clipped; qualified by out_valid.

Function
REQ-018 Pipeline SHALL be 2 stages: S1 registers full-width signed product (DATA_W+WEIGHT_W), S2 accumulates the sign-extended product into the ACC_W accumulator.
REQ-019 A tap counter 0..TAPS-1 SHALL advance once per accepted beat and wrap to 0 after the TAPS-th beat; the beat at count 0 marks vector start.
REQ-020 The first product of a vector SHALL load the accumulator (no add to the old value), so vectors run back-to-back with no bubble and no clear cycle.
REQ-021 The last-tap beat accepted at edge t SHALL produce out_valid=1 and result after edge t+2 (latency 2); throughput is 1 beat/cycle.
REQ-022 Output conversion SHALL be: r = (sum + 2^(SHIFT-1)) >>> SHIFT for SHIFT>0 (round-half-up, arithmetic), r = sum for SHIFT=0; result = r clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 iff clipped.
REQ-023 Accumulator overflow beyond ACC_W SHALL wrap two's-complement (no detection); ACC_W >= DATA_W+WEIGHT_W+clog2(TAPS) guarantees none.
REQ-024 stall = out_valid && !out_ready; while stall, S1, S2, counter and output registers SHALL hold and in_ready SHALL be 0; otherwise in_ready=1.
REQ-025 out_valid, result, sat SHALL stay stable until the handshake; on the handshake edge a new result from S2 SHALL replace it, else out_valid drops.
REQ-026 Beats offered with in_ready=0 SHALL be ignored, never lost or duplicated once accepted.
REQ-027 clear SHALL take priority over all other inputs: invalidate S1/S2, zero counter, drop out_valid; a beat offered in the clear cycle is dropped; in_ready is 1 the following cycle.

Reset
REQ-028 While rst=1: in_ready=0, out_valid=0, result=0, sat=0, counter=0, accumulator=0, S1/S2 valid=0.
REQ-029 rst asserted mid-vector SHALL discard the partial sum; the first beat after deassertion is tap 0.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Package mac_pkg SHALL hold default parameter constants and the clog2 constant function for counter width.
REQ-032 Rounding/saturation SHALL be a sub-module mac_round_sat (params ACC_W, OUT_W, SHIFT; in sum; out result, sat), combinational, instantiated once before the output register.

Verification
REQ-033 TAPS=8, SHIFT=0: data=1..8, weight=2 each cycle -> one out_valid pulse, result=72, sat=0, 2 cycles after 8th beat.
REQ-034 SHIFT=2: sum 6 -> result 2; sum -6 -> result -1; sum 5 -> result 1.
REQ-035 data=32767, weight=32767 x8 -> result=32767, sat=1; data=-32768, weight=32767 x8 -> result=-32768, sat=1.
REQ-036 Two vectors streamed back-to-back, out_ready=0 for 5 cycles after first out_valid -> in_ready=0 exactly those cycles, first result held stable, both results correct, 16 beats accepted total.
REQ-037 clear after 3 taps of a vector, then 8 taps data=1, weight=1 -> result=8, no result for the aborted vector.
REQ-038 rst pulse mid-vector with out_valid=1 -> all outputs 0 immediately (asynchronous), next 8-tap vector yields correct sum.
